// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART slot-bus arbiter.
// Slot addresses and status-word bit positions of the UART core.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_RST,
    S_CFG,
    S_IDLE,
    S_GAP
  } state_t;

  localparam logic [4:0] ADDR_DVSR = 5'd1;
  localparam logic [4:0] ADDR_TX   = 5'd2;
  localparam logic [4:0] ADDR_RX   = 5'd3;

  localparam int ST_TX_FULL  = 9;
  localparam int ST_RX_EMPTY = 8;

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a packet lock.
// The grant stays on one requester until its last byte is taken.
module rr_lock_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  input  logic             release_i,
  output logic [2:0]       grant_id_o,
  output logic             lock_o
);

  logic [2:0] rr_q;
  logic [2:0] grant_q;
  logic       lock_q;
  logic [2:0] pick;

  // Walk offsets high to low so the nearest requester after rr_q wins.
  always_comb begin
    pick = rr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if ((req_i & (N_REQ'(1) << j)) != '0) begin
        pick = 3'(j);
      end
    end
  end

  assign grant_id_o = lock_q ? grant_q : pick;
  assign lock_o     = lock_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q    <= 3'd0;
      grant_q <= 3'd0;
      lock_q  <= 1'b0;
    end else if (advance_i) begin
      if (release_i) begin
        lock_q <= 1'b0;
        rr_q   <= (grant_id_o == 3'(N_REQ - 1)) ?
                  3'd0 : grant_id_o + 3'd1;
      end else begin
        lock_q  <= 1'b1;
        grant_q <= grant_id_o;
      end
    end
  end

endmodule

// File: rtl/uart_slot_arbiter.sv
// Slot-bus master for the UART core: divisor setup, RX pop, TX arbitration.
// Every slot access is followed by one gap cycle so core FIFO flags settle.
module uart_slot_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [10:0] DVSR_INIT = 11'd650
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        cfg_dvsr,
  input  logic               cfg_load,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [2:0]         grant_id,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               m_cs,
  output logic               m_write,
  output logic               m_read,
  output logic [4:0]         m_addr,
  output logic [31:0]        m_wr_data,
  input  logic [31:0]        m_rd_data
);

  state_t      state_q, state_d;
  logic        cfg_pend_q;
  logic [10:0] cfg_val_q;
  logic [10:0] dvsr_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;

  logic [2:0]       grant;
  logic             lock_unused;
  logic [N_REQ-1:0] gnt_oh;
  logic [7:0]       tx_byte;
  logic             tx_last;
  logic             tx_full, rx_empty;
  logic             pop_ok, tx_ok;
  logic             do_pop, do_tx, take_cfg;
  logic             unused_status;

  assign tx_full       = m_rd_data[ST_TX_FULL];
  assign rx_empty      = m_rd_data[ST_RX_EMPTY];
  assign unused_status = ^m_rd_data[31:10];

  rr_lock_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .advance_i (do_tx),
    .release_i (do_tx & tx_last),
    .grant_id_o(grant),
    .lock_o    (lock_unused)
  );

  assign gnt_oh = N_REQ'(1) << grant;

  always_comb begin
    tx_byte = 8'h00;
    tx_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 3'(i)) begin
        tx_byte = req_data[8*i +: 8];
        tx_last = req_last[i];
      end
    end
  end

  assign pop_ok = !rx_empty && (!rx_valid_q || rx_ready);
  assign tx_ok  = !tx_full && ((req_valid & gnt_oh) != '0);

  // Bus strobes decode straight from state so reset silences them at once.
  always_comb begin
    state_d   = state_q;
    m_cs      = 1'b0;
    m_write   = 1'b0;
    m_addr    = 5'd0;
    m_wr_data = 32'd0;
    req_ready = '0;
    do_pop    = 1'b0;
    do_tx     = 1'b0;
    take_cfg  = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_CFG;
      S_CFG: begin
        m_cs      = 1'b1;
        m_write   = 1'b1;
        m_addr    = ADDR_DVSR;
        m_wr_data = {21'b0, dvsr_q};
        state_d   = S_GAP;
      end
      S_GAP: state_d = S_IDLE;
      S_IDLE: begin
        if (cfg_pend_q) begin
          take_cfg = 1'b1;
          state_d  = S_CFG;
        end else if (pop_ok) begin
          do_pop  = 1'b1;
          m_cs    = 1'b1;
          m_write = 1'b1;
          m_addr  = ADDR_RX;
          state_d = S_GAP;
        end else if (tx_ok) begin
          do_tx     = 1'b1;
          m_cs      = 1'b1;
          m_write   = 1'b1;
          m_addr    = ADDR_TX;
          m_wr_data = {24'b0, tx_byte};
          req_ready = gnt_oh;
          state_d   = S_GAP;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  assign m_read   = 1'b0;
  assign grant_id = grant;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      cfg_pend_q <= 1'b0;
      cfg_val_q  <= 11'd0;
      dvsr_q     <= DVSR_INIT;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        cfg_pend_q <= 1'b1;
        cfg_val_q  <= cfg_dvsr;
      end else if (take_cfg) begin
        cfg_pend_q <= 1'b0;
      end
      if (take_cfg) dvsr_q <= cfg_val_q;
      if (do_pop) begin
        rx_data_q  <= m_rd_data[7:0];
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Bench for uart_slot_arbiter: per-cycle reference model plus directed scenarios.
// Requester queues feed bytes; a monitor checks every output at the falling edge.
module tb_uart_slot_arbiter;

  localparam logic [10:0] DV_INIT = 11'd650;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cfg_dvsr = 11'd0;
  logic        cfg_load = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_last = 4'd0;
  logic [3:0]  req_ready;
  logic [2:0]  grant_id;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        m_cs, m_write, m_read;
  logic [4:0]  m_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data = 32'h100;

  uart_slot_arbiter #(.N_REQ(4), .DVSR_INIT(DV_INIT)) dut (
    .clk(clk), .reset(reset),
    .cfg_dvsr(cfg_dvsr), .cfg_load(cfg_load),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .grant_id(grant_id),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .m_cs(m_cs), .m_write(m_write), .m_read(m_read),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester byte queues: {last, byte}
  logic [8:0] txq [4][$];
  logic [3:0] rdy_s = 4'd0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rdy_s[i] && txq[i].size() > 0) void'(txq[i].pop_front());
      req_valid[i] = txq[i].size() > 0;
      req_data[8*i +: 8] = (txq[i].size() > 0) ? txq[i][0][7:0] : 8'h00;
      req_last[i] = (txq[i].size() > 0) ? txq[i][0][8] : 1'b0;
    end
  end

  // Reference model: what the bus must do this cycle given what came before.
  typedef struct {
    bit          started, cfgnow, gap, pend, rxv;
    logic [10:0] word, pval;
    logic [7:0]  rxd;
    int          own, rr;
  } mdl_t;

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.started = 0; m.cfgnow = 0; m.gap = 0; m.pend = 0; m.rxv = 0;
    m.word = 11'd0; m.pval = 11'd0; m.rxd = 8'h00;
    m.own = -1; m.rr = 0;
    return m;
  endfunction

  function automatic int pick_of(input logic [3:0] v, input int rr,
                                 input int own);
    if (own >= 0) return own;
    for (int k = 0; k < 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return rr;
  endfunction

  mdl_t cur, nxt;
  int tx_id[$];
  int tx_cyc[$];
  logic [7:0] tx_dat[$];
  logic prev_cs = 1'b0;

  always begin : mon
    logic        e_cs, pop;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_rdy;
    int          g;
    @(negedge clk);
    cyc++;
    rdy_s = req_ready;
    if (reset) cur = mdl_rst();
    nxt = cur;
    e_cs = 0; e_addr = 0; e_wd = 0; e_rdy = 0; pop = 0;
    g = pick_of(req_valid, cur.rr, cur.own);
    if (!reset) begin
      if (!cur.started) begin
        nxt.started = 1; nxt.cfgnow = 1; nxt.word = DV_INIT;
      end else if (cur.cfgnow) begin
        e_cs = 1; e_addr = 1; e_wd = {21'b0, cur.word};
        nxt.cfgnow = 0; nxt.gap = 1;
      end else if (cur.gap) begin
        nxt.gap = 0;
      end else if (cur.pend) begin
        nxt.cfgnow = 1; nxt.word = cur.pval; nxt.pend = 0;
      end else if (!m_rd_data[8] && (!cur.rxv || rx_ready)) begin
        e_cs = 1; e_addr = 3; pop = 1; nxt.gap = 1;
      end else if (!m_rd_data[9] && req_valid[g]) begin
        e_cs = 1; e_addr = 2; e_wd = {24'b0, req_data[8*g +: 8]};
        e_rdy = 4'(1 << g); nxt.gap = 1;
        if (req_last[g]) begin
          nxt.own = -1; nxt.rr = (g + 1) % 4;
        end else begin
          nxt.own = g;
        end
      end
      if (pop) begin
        nxt.rxd = m_rd_data[7:0]; nxt.rxv = 1;
      end else if (rx_ready) begin
        nxt.rxv = 0;
      end
      if (cfg_load) begin
        nxt.pend = 1; nxt.pval = cfg_dvsr;
      end
    end
    cmp("m_cs", 32'(m_cs), 32'(e_cs));
    cmp("m_write", 32'(m_write), 32'(e_cs));
    cmp("m_read", 32'(m_read), 32'd0);
    cmp("m_addr", 32'(m_addr), 32'(e_addr));
    cmp("m_wr_data", m_wr_data, e_wd);
    cmp("req_ready", 32'(req_ready), 32'(e_rdy));
    cmp("grant_id", 32'(grant_id), 32'(g));
    cmp("rx_valid", 32'(rx_valid), 32'(cur.rxv));
    cmp("rx_data", 32'(rx_data), 32'(cur.rxd));
    cmp("no_back_to_back", 32'(m_cs & prev_cs), 32'd0);
    if (!reset && m_cs && m_addr == 5'd2) begin
      tx_id.push_back(int'(grant_id));
      tx_cyc.push_back(cyc);
      tx_dat.push_back(m_wr_data[7:0]);
    end
    prev_cs = m_cs;
    @(posedge clk);
    if (reset) cur = mdl_rst();
    else cur = nxt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(input string nm, input logic [4:0] a,
                         input int budget, output logic [31:0] d);
    bit found = 0;
    d = 32'd0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (m_cs && m_addr == a) begin
        found = 1;
        d = m_wr_data;
      end
    end
    cmp({nm, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && tx_id.size() < n; i++) @(negedge clk);
    cmp("tx_log_size", 32'(tx_id.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int cnt;
    // 1: reset and automatic divisor write
    @(negedge clk);
    cmp("rst_m_cs", 32'(m_cs), 32'd0);
    cmp("rst_grant", 32'(grant_id), 32'd0);
    cmp("rst_rx_valid", 32'(rx_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    cmp("boot_rst_idle", 32'(m_cs), 32'd0);
    @(negedge clk);
    cmp("boot_cfg_cs", 32'(m_cs), 32'd1);
    cmp("boot_cfg_addr", 32'(m_addr), 32'd1);
    cmp("boot_cfg_data", m_wr_data, 32'h28A);
    @(negedge clk);
    cmp("boot_gap", 32'(m_cs), 32'd0);
    @(negedge clk);
    cmp("boot_idle", 32'(m_cs), 32'd0);

    // 2: three-byte packet from req0 holds off req1
    txq[0].push_back(9'h0A0);
    txq[0].push_back(9'h0A1);
    txq[0].push_back(9'h1A2);
    txq[1].push_back(9'h1B1);
    wait_log(4, 30);
    cmp("pkt_id0", 32'(tx_id[0]), 32'd0);
    cmp("pkt_id1", 32'(tx_id[1]), 32'd0);
    cmp("pkt_id2", 32'(tx_id[2]), 32'd0);
    cmp("pkt_id3", 32'(tx_id[3]), 32'd1);
    cmp("pkt_dat1", 32'(tx_dat[1]), 32'hA1);
    cmp("pkt_dat3", 32'(tx_dat[3]), 32'hB1);
    cmp("pkt_gap01", 32'(tx_cyc[1] - tx_cyc[0]), 32'd2);
    cmp("pkt_gap12", 32'(tx_cyc[2] - tx_cyc[1]), 32'd2);

    // 3: all requesters with single-byte packets, fresh rr pointer
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tx_id.delete(); tx_cyc.delete(); tx_dat.delete();
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) txq[i].push_back(9'h100 | 9'(8'hC0 + 4*r + i));
    wait_log(8, 60);
    for (int i = 0; i < 5; i++) cmp($sformatf("rr_order%0d", i),
                                   32'(tx_id[i]), 32'(i % 4));
    cmp("rr_dat4", 32'(tx_dat[4]), 32'hC4);

    // 4: tx_full blocks TX writes
    tick();
    m_rd_data = 32'h300;
    @(negedge clk);
    txq[0].push_back(9'h0D0);
    txq[0].push_back(9'h1D1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_cs && m_addr == 5'd2) cnt++;
      if (req_ready != 4'd0) cnt++;
    end
    cmp("full_no_tx", 32'(cnt), 32'd0);
    tick();
    m_rd_data = 32'h100;
    @(negedge clk);
    cmp("full_resume_cs", 32'(m_cs), 32'd1);
    cmp("full_resume_addr", 32'(m_addr), 32'd2);
    cmp("full_resume_data", m_wr_data, 32'hD0);
    wait_op("d1", 5'd2, 6, d);

    // 5: RX pop, hold, and pop with accept; pop preempts TX
    txq[1].push_back(9'h1F1);
    tick();
    m_rd_data = 32'h05A;
    @(negedge clk);
    @(negedge clk);
    cmp("rx_pop_addr", 32'(m_addr), 32'd3);
    cmp("rx_pop_cs", 32'(m_cs), 32'd1);
    cmp("rx_pop_no_ready", 32'(req_ready), 32'd0);
    tick();
    m_rd_data = 32'h06B;
    wait_op("tx_f1", 5'd2, 6, d);
    cmp("tx_f1_data", d, 32'hF1);
    cmp("rx_hold_data", 32'(rx_data), 32'h5A);
    cmp("rx_hold_valid", 32'(rx_valid), 32'd1);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_cs && m_addr == 5'd3) cnt++;
    end
    cmp("rx_no_second_pop", 32'(cnt), 32'd0);
    tick();
    rx_ready = 1'b1;
    wait_op("rx_pop2", 5'd3, 6, d);
    tick();
    m_rd_data = 32'h100;
    @(negedge clk);
    cmp("rx_pop2_data", 32'(rx_data), 32'h6B);
    cmp("rx_pop2_valid", 32'(rx_valid), 32'd1);
    @(negedge clk);
    cmp("rx_drained", 32'(rx_valid), 32'd0);
    tick();
    rx_ready = 1'b0;

    // 6: divisor update inside a locked packet, then reset mid-packet
    @(negedge clk);
    txq[0].push_back(9'h0E0);
    txq[0].push_back(9'h0E1);
    txq[0].push_back(9'h1E2);
    wait_op("e0", 5'd2, 8, d);
    cmp("e0_data", d, 32'hE0);
    tick();
    cfg_load = 1'b1;
    cfg_dvsr = 11'h145;
    tick();
    cfg_load = 1'b0;
    wait_op("cfg145", 5'd1, 6, d);
    cmp("cfg145_data", d, 32'h145);
    wait_op("e1", 5'd2, 6, d);
    cmp("e1_data", d, 32'hE1);
    cmp("e1_grant", 32'(grant_id), 32'd0);
    tick();
    cfg_load = 1'b1;
    cfg_dvsr = 11'h0FF;
    tick();
    cfg_load = 1'b0;
    wait_op("cfg0ff", 5'd1, 6, d);
    cmp("cfg0ff_data", d, 32'h0FF);
    #1 reset = 1'b1;
    #1;
    cmp("async_m_cs", 32'(m_cs), 32'd0);
    cmp("async_m_addr", 32'(m_addr), 32'd0);
    cmp("async_m_wr_data", m_wr_data, 32'd0);
    cmp("async_rx_data", 32'(rx_data), 32'd0);
    cmp("async_rx_valid", 32'(rx_valid), 32'd0);
    cmp("async_grant", 32'(grant_id), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    wait_op("reboot_cfg", 5'd1, 6, d);
    cmp("reboot_cfg_data", d, 32'h28A);
    wait_op("e2", 5'd2, 8, d);
    cmp("e2_data", d, 32'hE2);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
